// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline stage register carrying a packed DATA_W payload between
//   two valid/ready interfaces. With SKID=1 a second (skid) entry absorbs the
//   one extra beat that arrives after downstream stalls, so in_ready is driven
//   purely from a flop. With SKID=0 the stage holds a single entry and
//   in_ready is combinational from out_ready.
//   Also provides a synchronous flush (bubble insertion) and a saturating
//   counter of stalled output cycles for profiling.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   flush      synchronous flush, discards all held entries and any input
//   in_valid   upstream payload valid
//   in_data    upstream payload
//   in_ready   stage can accept this cycle
//   out_valid  downstream payload valid
//   out_data   downstream payload (qualify with out_valid)
//   out_ready  downstream accepts; 0 = stall
//   stat_clr   synchronous clear of stall_cnt
//   stall_cnt  saturating count of cycles with out_valid & ~out_ready
//   occupancy  number of entries held (0..2, max 1 when SKID=0)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = {DATA_W{1'b0}},
  parameter int                 SKID      = 1,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        occupancy
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] main_q,      main_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_q,      skid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic in_fire;
  logic out_fire;
  logic main_can_load;

  // With a skid entry, in_ready depends only on state; the skid slot is what
  // catches the beat accepted in the same cycle downstream stalls.
  always_comb begin
    if (SKID != 0) begin
      in_ready = ~skid_valid_q;
    end else begin
      in_ready = out_ready | ~out_valid_q;
    end
  end

  assign in_fire       = in_valid & in_ready;
  assign out_fire      = out_valid_q & out_ready;
  assign main_can_load = ~out_valid_q | out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;

    if (flush) begin
      // Flush wins over everything; an input beat offered now is dropped.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      main_d       = FLUSH_VAL;
    end else if (SKID != 0) begin
      if (main_can_load) begin
        // The skid entry is older than anything on in_data, so it goes first.
        // in_ready is low while the skid is full, so both cannot happen at once.
        if (skid_valid_q) begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end else if (in_fire) begin
          main_d = in_data;
        end
        out_valid_d = skid_valid_q | in_fire;
      end else if (in_fire) begin
        skid_d       = in_data;
        skid_valid_d = 1'b1;
      end
    end else begin
      if (in_fire) begin
        main_d      = in_data;
        out_valid_d = 1'b1;
      end else if (out_fire) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Stall counter is deliberately independent of flush so profiling spans
  // pipeline redirects.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid_q && !out_ready && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      main_q       <= FLUSH_VAL;
      skid_valid_q <= 1'b0;
      skid_q       <= FLUSH_VAL;
      stall_cnt_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      main_q       <= main_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign stall_cnt = stall_cnt_q;
  assign occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Three instances: a (SKID=1, 16-bit counter), s (SKID=1, 4-bit counter for
//   saturation), z (SKID=0). Directed stimulus pushes expected payloads into
//   per-instance queues; negedge monitors pop and compare on every out_fire.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam logic [DW-1:0] FV = 16'hDEAD;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // instance a
  logic a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_stat_clr;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [15:0] a_stall;
  logic [1:0] a_occ;
  // instance s
  logic s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_stat_clr;
  logic [DW-1:0] s_in_data, s_out_data;
  logic [3:0] s_stall;
  logic [1:0] s_occ;
  // instance z
  logic z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_stat_clr;
  logic [DW-1:0] z_in_data, z_out_data;
  logic [7:0] z_stall;
  logic [1:0] z_occ;

  pipe_stage_reg #(.DATA_W(DW), .FLUSH_VAL(FV), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid),
    .in_data(a_in_data), .in_ready(a_in_ready), .out_valid(a_out_valid),
    .out_data(a_out_data), .out_ready(a_out_ready), .stat_clr(a_stat_clr),
    .stall_cnt(a_stall), .occupancy(a_occ));

  pipe_stage_reg #(.DATA_W(DW), .FLUSH_VAL(FV), .SKID(1), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .flush(s_flush), .in_valid(s_in_valid),
    .in_data(s_in_data), .in_ready(s_in_ready), .out_valid(s_out_valid),
    .out_data(s_out_data), .out_ready(s_out_ready), .stat_clr(s_stat_clr),
    .stall_cnt(s_stall), .occupancy(s_occ));

  pipe_stage_reg #(.DATA_W(DW), .FLUSH_VAL(FV), .SKID(0), .CNT_W(8)) dut_z (
    .clk(clk), .reset(reset), .flush(z_flush), .in_valid(z_in_valid),
    .in_data(z_in_data), .in_ready(z_in_ready), .out_valid(z_out_valid),
    .out_data(z_out_data), .out_ready(z_out_ready), .stat_clr(z_stat_clr),
    .stall_cnt(z_stall), .occupancy(z_occ));

  logic [DW-1:0] sb_a[$];
  logic [DW-1:0] sb_z[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: a transfer happens at the next posedge whenever
  // out_valid & out_ready are high at the negedge (inputs change only at +1).
  always @(negedge clk) begin
    if (!reset && a_out_valid && a_out_ready) begin
      if (sb_a.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL a_out_unexpected: got %h, expected no transfer", a_out_data);
      end else begin
        chk("a_out", {16'h0, a_out_data}, {16'h0, sb_a.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("z_occ_le1", {31'h0, (z_occ <= 2'd1)}, 32'd1);
      if (z_out_valid && z_out_ready) begin
        if (sb_z.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL z_out_unexpected: got %h, expected no transfer", z_out_data);
        end else begin
          chk("z_out", {16'h0, z_out_data}, {16'h0, sb_z.pop_front()});
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    a_flush = 0; a_in_valid = 1; a_in_data = 16'h1234; a_out_ready = 1; a_stat_clr = 0;
    s_flush = 0; s_in_valid = 0; s_in_data = 0;        s_out_ready = 1; s_stat_clr = 0;
    z_flush = 0; z_in_valid = 0; z_in_data = 0;        z_out_ready = 1; z_stat_clr = 0;

    // ---------------- reset / idle ----------------
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data",  a_out_data, FV);
    step(); step();
    chk("rst_out_valid_clk", a_out_valid, 0);
    chk("rst_in_ready",  a_in_ready, 1);
    chk("rst_stall",     a_stall, 0);
    chk("rst_occ",       a_occ, 0);
    chk("rst_z_in_ready", z_in_ready, 1);
    reset = 1'b0; a_in_valid = 0;
    step();

    // ---------------- streaming ----------------
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1; a_in_data = 16'hA0 + 16'(i);
      sb_a.push_back(16'hA0 + 16'(i));
      chk("stream_in_ready", a_in_ready, 1);
      step();
      chk("stream_latency", {15'h0, a_out_valid, a_out_data}, {15'h0, 1'b1, 16'hA0 + 16'(i)});
    end
    a_in_valid = 0;
    step();
    chk("stream_drained", a_out_valid, 0);

    // ---------------- backpressure ----------------
    a_in_valid = 1; a_in_data = 16'hB0; sb_a.push_back(16'hB0);
    step();
    a_out_ready = 0; a_in_data = 16'hB1; sb_a.push_back(16'hB1);
    step();
    a_in_data = 16'hB2; sb_a.push_back(16'hB2);
    for (int i = 0; i < 4; i++) step();
    chk("bp_out_data", a_out_data, 16'hB0);
    chk("bp_in_ready", a_in_ready, 0);
    chk("bp_occ",      a_occ, 2);
    chk("bp_stall",    a_stall, 5);
    a_out_ready = 1;
    step();
    chk("bp_rel1_data", a_out_data, 16'hB1);
    chk("bp_rel1_occ",  a_occ, 1);
    chk("bp_rel1_rdy",  a_in_ready, 1);
    step();
    a_in_valid = 0;
    chk("bp_rel2_data", a_out_data, 16'hB2);
    step();
    chk("bp_empty", a_occ, 0);
    chk("bp_sb_empty", sb_a.size(), 0);
    chk("bp_stall_hold", a_stall, 5);

    // ---------------- flush with full skid ----------------
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 16'hD0;
    step();
    a_in_data = 16'hD1;
    step();
    chk("fl_occ_full", a_occ, 2);
    a_flush = 1; a_in_data = 16'hC0;
    step();
    a_flush = 0; a_in_valid = 0;
    chk("fl_out_valid", a_out_valid, 0);
    chk("fl_occ",       a_occ, 0);
    chk("fl_out_data",  a_out_data, FV);
    chk("fl_stall",     a_stall, 7);
    a_out_ready = 1;
    step(); step();
    chk("fl_no_c0", a_out_valid, 0);
    // flush discards a beat accepted on an empty stage
    a_flush = 1; a_in_valid = 1; a_in_data = 16'hE0;
    step();
    a_flush = 0; a_in_valid = 0;
    chk("fl_empty_drop", a_out_valid, 0);
    a_stat_clr = 1;
    step();
    a_stat_clr = 0;
    chk("a_stat_clr", a_stall, 0);

    // ---------------- saturation (CNT_W=4) ----------------
    s_out_ready = 0; s_in_valid = 1; s_in_data = 16'h0055;
    step();
    s_in_valid = 0;
    chk("sat_valid", s_out_valid, 1);
    for (int i = 0; i < 14; i++) step();
    chk("sat_14", s_stall, 14);
    step();
    chk("sat_15", s_stall, 15);
    for (int i = 0; i < 5; i++) step();
    chk("sat_hold", s_stall, 15);
    s_stat_clr = 1;
    step();
    s_stat_clr = 0;
    chk("sat_clr_prio", s_stall, 0);
    step();
    chk("sat_restart", s_stall, 1);

    // ---------------- SKID=0 ----------------
    z_in_valid = 1; z_in_data = 16'h0010; sb_z.push_back(16'h0010);
    step();
    z_in_valid = 0;
    chk("z_load", z_out_data, 16'h0010);
    z_out_ready = 0; #1;
    chk("z_comb_rdy0", z_in_ready, 0);
    z_out_ready = 1; #1;
    chk("z_comb_rdy1", z_in_ready, 1);
    z_out_ready = 0; z_in_valid = 1; z_in_data = 16'h0011; sb_z.push_back(16'h0011);
    step();
    chk("z_hold_data", z_out_data, 16'h0010);
    chk("z_occ1",      z_occ, 1);
    chk("z_stall",     z_stall, 1);
    z_out_ready = 1;
    step();
    z_in_valid = 0;
    chk("z_next_data", z_out_data, 16'h0011);
    step();
    chk("z_drained", z_out_valid, 0);
    chk("z_sb_empty", sb_z.size(), 0);

    // ---------------- async reset mid-transfer ----------------
    a_out_ready = 0; a_in_valid = 1; a_in_data = 16'h00F0;
    step();
    a_in_valid = 0;
    chk("mr_loaded", a_out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("mr_out_valid", a_out_valid, 0);
    chk("mr_occ",       a_occ, 0);
    chk("mr_out_data",  a_out_data, FV);
    chk("mr_stall",     a_stall, 0);
    step();
    reset = 1'b0;
    step();
    chk("final_sb_a", sb_a.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
